dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive CPU grants while loader waits (range 1..15).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port cpu_req  in  1  MEM-stage access request (MemRd or MemWr).
REQ-005 SHALL have port cpu_wr  in  1  1=write, 0=read.
REQ-006 SHALL have ports cpu_addr / cpu_wdata  in  32 each  CPU address / write data.
REQ-007 SHALL have ports cpu_rdata  out  32 and cpu_stall  out  1  read data; pipeline freeze request.
REQ-008 SHALL have ports ld_req, ld_wr  in  1; ld_addr, ld_wdata  in  32  loader/DMA request.
REQ-009 SHALL have ports ld_gnt  out  1; ld_rdata  out  32; ld_rvalid  out  1  loader grant / read return.
REQ-010 SHALL have ports mem_en, mem_wr  out  1; mem_addr, mem_wdata  out  32; mem_rdata  in  32  memory port, read data 1 cycle after mem_en.

Function
REQ-011 SHALL issue at most one grant per cycle; grant is combinational in the request cycle and drives mem_en/mem_wr/mem_addr/mem_wdata from the granted requester; all mem_* 0 when no grant.
REQ-012 SHALL run FSM states IDLE, RD_CPU, RD_LD (read return owner); read grant to X -> RD_X next cycle, otherwise -> IDLE; applies from any state.
REQ-013 SHALL exclude CPU from arbitration in RD_CPU and loader in RD_LD; the other requester may be granted in that cycle (back-to-back pipelined access).
REQ-014 SHALL in RD_CPU drive cpu_rdata = mem_rdata; in RD_LD drive ld_rdata = mem_rdata, ld_rvalid = 1; otherwise rdata outputs 0, ld_rvalid 0.
REQ-015 SHALL assert cpu_stall = cpu_req AND NOT (CPU write granted this cycle OR state RD_CPU); CPU read costs exactly 1 stall cycle when uncontended.
REQ-016 SHALL grant CPU over loader on simultaneous eligible requests, unless streak counter equals STARVE_LIMIT, then grant loader.
REQ-017 SHALL increment 4-bit streak counter on each CPU grant while ld_req=1, saturate at STARVE_LIMIT, clear on loader grant or when ld_req=0.
REQ-018 SHALL assert ld_gnt only in the grant cycle; loader holds request fields stable until ld_gnt, may change them the cycle after.
REQ-019 SHALL never grant a requester whose req=0; idle cycles leave counter unchanged except per REQ-017.

Reset
REQ-020 SHALL, while rst=1, force state IDLE, counter 0, all grants/mem_en/ld_gnt/ld_rvalid/cpu_stall 0, rdata outputs 0.
REQ-021 SHALL discard any pending read when rst asserts mid-operation: no ld_rvalid and no RD_CPU cycle after reset release.
REQ-022 SHALL allow a grant in the first cycle after rst deasserts.

Structure
REQ-023 SHALL place state enum (IDLE/RD_CPU/RD_LD, 2 bits) and owner encoding (CPU=0, LD=1) in shared package cpu_pkg with default STARVE_LIMIT constant.
REQ-024 SHALL implement the streak counter as sub-module starve_cnt (inputs inc, clr, limit; output at_limit); FSM and muxing stay in dmem_arbiter.

Verification
REQ-025 SHALL cover: CPU read addr 0x10 alone, mem returns 0xDEADBEEF -> cpu_stall high 1 cycle, cpu_rdata=0xDEADBEEF in RD_CPU cycle, cpu_stall low.
REQ-026 SHALL cover: CPU write 0x20 and loader write 0x24 same cycle -> CPU granted, cpu_stall 0; loader granted next cycle, ld_gnt pulse 1 cycle.
REQ-027 SHALL cover: ld_req held, CPU requesting every cycle, STARVE_LIMIT=4 -> loader granted on cycle 5 of contention, counter reads 0 after.
REQ-028 SHALL cover: CPU read then loader read back-to-back -> loader granted in RD_CPU cycle, ld_rvalid next cycle with correct data, no collision.
REQ-029 SHALL cover: rst asserted in cycle after loader read grant -> ld_rvalid never asserts; all outputs 0 during rst; grant possible first post-reset cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the data-memory arbiter: read-return state encoding,
// requester owner encoding and the default CPU streak limit.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_CPU = 2'd1,
    ST_RD_LD  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/starve_cnt.sv
// Counts consecutive CPU grants made while the loader is waiting; saturates
// at the configured limit so the arbiter can force a loader turn.
module starve_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic [3:0] limit,
  output logic       at_limit
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt != limit)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_limit = (cnt == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory shared between the CPU MEM stage and a loader/DMA.
// One grant per cycle, 1-cycle read latency, CPU priority with starvation guard.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | no read data returning this cycle
//   ST_RD_CPU | mem_rdata belongs to the CPU; CPU excluded from arbitration
//   ST_RD_LD  | mem_rdata belongs to the loader; loader excluded
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ld_req,
  input  logic        ld_wr,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,
  output logic [31:0] ld_rdata,
  output logic        ld_rvalid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_e state, state_next;
  owner_e     gnt_owner;
  logic       cpu_elig, ld_elig, gnt_valid;
  logic       gnt_cpu, gnt_ld;
  logic       at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  starve_cnt u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (gnt_cpu && ld_req),
    .clr      (gnt_ld || !ld_req),
    .limit    (4'(STARVE_LIMIT)),
    .at_limit (at_limit)
  );

  always_comb begin
    cpu_elig   = cpu_req && (state != ST_RD_CPU);
    ld_elig    = ld_req && (state != ST_RD_LD);
    gnt_valid  = !rst && (cpu_elig || ld_elig);
    // CPU wins a tie unless it has already held the port STARVE_LIMIT times
    gnt_owner  = (ld_elig && (!cpu_elig || at_limit)) ? OWN_LD : OWN_CPU;
    gnt_cpu    = gnt_valid && (gnt_owner == OWN_CPU);
    gnt_ld     = gnt_valid && (gnt_owner == OWN_LD);

    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    state_next = ST_IDLE;

    if (gnt_cpu) begin
      mem_en    = 1'b1;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (!cpu_wr) state_next = ST_RD_CPU;
    end else if (gnt_ld) begin
      mem_en    = 1'b1;
      mem_wr    = ld_wr;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      if (!ld_wr) state_next = ST_RD_LD;
    end

    ld_gnt    = gnt_ld;
    // State may still show a pending read during the first reset cycle; mask it
    cpu_rdata = (!rst && (state == ST_RD_CPU)) ? mem_rdata : 32'd0;
    ld_rdata  = (!rst && (state == ST_RD_LD))  ? mem_rdata : 32'd0;
    ld_rvalid = !rst && (state == ST_RD_LD);
    cpu_stall = !rst && cpu_req && !((gnt_cpu && cpu_wr) || (state == ST_RD_CPU));
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle-by-cycle vector table with
// hand-computed outputs, then a reset-during-read sequence.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ld_req, ld_wr;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic        ld_gnt, ld_rvalid;
  logic        mem_en, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ld_req    (ld_req),
    .ld_wr     (ld_wr),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_gnt    (ld_gnt),
    .ld_rdata  (ld_rdata),
    .ld_rvalid (ld_rvalid),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        rst;
    logic        creq, cwr;
    logic [31:0] caddr, cwd;
    logic        lreq, lwr;
    logic [31:0] laddr, lwd;
    logic [31:0] mrd;
    logic        e_stall, e_gnt, e_en, e_wr;
    logic [31:0] e_addr, e_wd, e_crd, e_lrd;
    logic        e_rv;
    logic [3:0]  e_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  function automatic vec_t mk(
    logic r, logic creq, logic cwr, logic [31:0] caddr, logic [31:0] cwd,
    logic lreq, logic lwr, logic [31:0] laddr, logic [31:0] lwd, logic [31:0] mrd,
    logic e_stall, logic e_gnt, logic e_en, logic e_wr, logic [31:0] e_addr,
    logic [31:0] e_wd, logic [31:0] e_crd, logic [31:0] e_lrd, logic e_rv,
    logic [3:0] e_cnt);
    vec_t v;
    v.rst = r; v.creq = creq; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
    v.lreq = lreq; v.lwr = lwr; v.laddr = laddr; v.lwd = lwd; v.mrd = mrd;
    v.e_stall = e_stall; v.e_gnt = e_gnt; v.e_en = e_en; v.e_wr = e_wr;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_crd = e_crd; v.e_lrd = e_lrd;
    v.e_rv = e_rv; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [199:0] got, input logic [199:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    cpu_req = v.creq; cpu_wr = v.cwr; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    ld_req = v.lreq; ld_wr = v.lwr; ld_addr = v.laddr; ld_wdata = v.lwd;
    mem_rdata = v.mrd;
  endtask

  function automatic logic [199:0] outs_now();
    return {cpu_stall, ld_gnt, mem_en, mem_wr, mem_addr, mem_wdata,
            cpu_rdata, ld_rdata, ld_rvalid, dut.u_starve.cnt};
  endfunction

  initial begin
    vec_t idle;
    // rst creq cwr caddr cwd | lreq lwr laddr lwd | mrd || stall gnt en wr addr wd crd lrd rv cnt
    vecs[0]  = mk(1, 1,0,32'h10,0,            1,0,32'h44,0,            32'h1234,
                  0,0,0,0,0,0,0,0,0,0);
    vecs[1]  = mk(0, 1,0,32'h10,0,            0,0,0,0,                 32'h0,
                  1,0,1,0,32'h10,0,0,0,0,0);
    vecs[2]  = mk(0, 1,0,32'h10,0,            0,0,0,0,                 32'hDEADBEEF,
                  0,0,0,0,0,0,32'hDEADBEEF,0,0,0);
    vecs[3]  = mk(0, 1,1,32'h20,32'hA5A5A5A5, 1,1,32'h24,32'h5A5A5A5A, 32'hDEADBEEF,
                  0,0,1,1,32'h20,32'hA5A5A5A5,0,0,0,0);
    vecs[4]  = mk(0, 0,0,0,0,                 1,1,32'h24,32'h5A5A5A5A, 32'hDEADBEEF,
                  0,1,1,1,32'h24,32'h5A5A5A5A,0,0,0,1);
    vecs[5]  = mk(0, 0,0,0,0,                 0,0,0,0,                 32'hDEADBEEF,
                  0,0,0,0,0,0,0,0,0,0);
    vecs[6]  = mk(0, 1,0,32'h30,0,            0,0,0,0,                 32'h0,
                  1,0,1,0,32'h30,0,0,0,0,0);
    vecs[7]  = mk(0, 1,0,32'h30,0,            1,0,32'h40,0,            32'h11112222,
                  0,1,1,0,32'h40,0,32'h11112222,0,0,0);
    vecs[8]  = mk(0, 0,0,0,0,                 0,0,0,0,                 32'h33334444,
                  0,0,0,0,0,0,0,32'h33334444,1,0);
    vecs[9]  = mk(0, 1,1,32'h50,32'h1,        1,1,32'h60,32'h6,        32'h0,
                  0,0,1,1,32'h50,32'h1,0,0,0,0);
    vecs[10] = mk(0, 1,1,32'h54,32'h2,        1,1,32'h60,32'h6,        32'h0,
                  0,0,1,1,32'h54,32'h2,0,0,0,1);
    vecs[11] = mk(0, 1,1,32'h58,32'h3,        1,1,32'h60,32'h6,        32'h0,
                  0,0,1,1,32'h58,32'h3,0,0,0,2);
    vecs[12] = mk(0, 1,1,32'h5C,32'h4,        1,1,32'h60,32'h6,        32'h0,
                  0,0,1,1,32'h5C,32'h4,0,0,0,3);
    vecs[13] = mk(0, 1,1,32'h68,32'h5,        1,1,32'h60,32'h6,        32'h0,
                  1,1,1,1,32'h60,32'h6,0,0,0,4);
    vecs[14] = mk(0, 1,1,32'h68,32'h5,        0,0,0,0,                 32'h0,
                  0,0,1,1,32'h68,32'h5,0,0,0,0);
    vecs[15] = mk(0, 0,0,0,0,                 1,0,32'h70,0,            32'h0,
                  0,1,1,0,32'h70,0,0,0,0,0);
    vecs[16] = mk(1, 1,0,32'h90,0,            0,0,0,0,                 32'hCAFEF00D,
                  0,0,0,0,0,0,0,0,0,0);
    vecs[17] = mk(0, 1,1,32'h80,32'h12345678, 0,0,0,0,                 32'hCAFEF00D,
                  0,0,1,1,32'h80,32'h12345678,0,0,0,0);
    vecs[18] = mk(0, 1,0,32'h90,0,            1,0,32'h94,0,            32'h0,
                  1,0,1,0,32'h90,0,0,0,0,0);
    vecs[19] = mk(0, 1,0,32'h90,0,            1,0,32'h94,0,            32'hABCD0001,
                  0,1,1,0,32'h94,0,32'hABCD0001,0,0,1);
    vecs[20] = mk(0, 1,0,32'hA0,0,            1,0,32'h98,0,            32'hABCD0002,
                  1,0,1,0,32'hA0,0,0,32'hABCD0002,1,0);
    vecs[21] = mk(0, 0,0,0,0,                 0,0,0,0,                 32'hABCD0003,
                  0,0,0,0,0,0,32'hABCD0003,0,0,1);

    idle = mk(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0,0,0,0,0);

    drive(vecs[0]);
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk($sformatf("vec%0d", i), outs_now(),
          {vecs[i].e_stall, vecs[i].e_gnt, vecs[i].e_en, vecs[i].e_wr,
           vecs[i].e_addr, vecs[i].e_wd, vecs[i].e_crd, vecs[i].e_lrd,
           vecs[i].e_rv, vecs[i].e_cnt});
    end

    // Reset held two cycles right after a loader read grant
    @(negedge clk);
    drive(idle);
    ld_req = 1'b1; ld_addr = 32'hB0;
    #2;
    chk("ld_read_grant", {ld_gnt, mem_en, mem_wr, mem_addr}, {1'b1, 1'b1, 1'b0, 32'hB0});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(idle);
      rst = 1'b1; cpu_req = 1'b1; mem_rdata = 32'hFFFFFFFF;
      #2;
      chk($sformatf("rst_outputs%0d", i), outs_now(), '0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(idle);
      mem_rdata = 32'hFFFFFFFF;
      #2;
      chk($sformatf("post_rst_no_return%0d", i),
          {ld_rvalid, ld_rdata, cpu_rdata, mem_en}, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
